mcpu_soc_audio_sample_fifo: RTL and testbench

MCPU_SOC_AUDIO_SAMPLE_FIFO -- requirements
Module: mcpu_soc_audio_sample_fifo

---
 rtl/mcpu_soc_audio_pkg.sv | 13 +
 rtl/mcpu_soc_audio_sample_fifo_if.sv | 29 ++
 rtl/mcpu_soc_audio_fifo_ram.sv | 36 +++
 rtl/mcpu_soc_audio_sample_fifo.sv | 139 +++++++++++++
 tb/tb_mcpu_soc_audio_sample_fifo.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/mcpu_soc_audio_pkg.sv
// Shared audio types and defaults for the sample FIFO and the I2S serializer.
package mcpu_soc_audio_pkg;

  localparam int SAMPLE_W      = 16;
  localparam int DEPTH_DEFAULT = 64;
  localparam int AW_DEFAULT    = 6;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } stereo_sample_t;

endpackage

// File: rtl/mcpu_soc_audio_sample_fifo_if.sv
// Producer/serializer-facing signal bundle of the audio sample FIFO.
interface mcpu_soc_audio_sample_fifo_if
  import mcpu_soc_audio_pkg::*;
#(
  parameter int AW = AW_DEFAULT
);
  logic                      enable;
  logic                      wr_valid;
  logic [2*SAMPLE_W-1:0]     wr_data;
  logic                      wr_ready;
  logic                      rd_req;
  logic [SAMPLE_W-1:0]       rd_left;
  logic [SAMPLE_W-1:0]       rd_right;
  logic [AW:0]               level;
  logic [AW:0]               lowwater;
  logic                      irq_low;
  logic                      underrun;
  logic                      underrun_clr;

  modport master (
    output enable, wr_valid, wr_data, rd_req, lowwater, underrun_clr,
    input  wr_ready, rd_left, rd_right, level, irq_low, underrun
  );

  modport slave (
    input  enable, wr_valid, wr_data, rd_req, lowwater, underrun_clr,
    output wr_ready, rd_left, rd_right, level, irq_low, underrun
  );
endinterface

// File: rtl/mcpu_soc_audio_fifo_ram.sv
// Simple dual-port sample store: one write port, one synchronous read port.
// Contents are deliberately not reset; the control logic never exposes unread slots.
module mcpu_soc_audio_fifo_ram
  import mcpu_soc_audio_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = AW_DEFAULT
) (
  input  logic           i_clk,
  input  logic           i_we,
  input  logic [AW-1:0]  i_waddr,
  input  stereo_sample_t i_wdata,
  input  logic           i_re,
  input  logic [AW-1:0]  i_raddr,
  output stereo_sample_t o_rdata
);

  stereo_sample_t r_mem [DEPTH];
  stereo_sample_t r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read data only moves on a read strobe, so it holds the last popped sample.
  always_ff @(posedge i_clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mcpu_soc_audio_sample_fifo.sv
// Stereo PCM sample FIFO between the CPU/DMA producer and the I2S serializer.
// Pointers, occupancy and flags live here; storage is the dual-port RAM below.
module mcpu_soc_audio_sample_fifo
  import mcpu_soc_audio_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = AW_DEFAULT
) (
  input  logic                          clkrst_core_clk,
  input  logic                          clkrst_core_rst,
  mcpu_soc_audio_sample_fifo_if.slave   bus
);

  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ZERO = (AW+1)'(1'b0);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1'b1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(1'b0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);

  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [AW:0]    r_level;
  logic           r_not_full;
  logic           r_out_valid;
  logic           r_underrun;
  logic           r_irq_low;

  logic           w_wr_ready;
  logic           w_push;
  logic           w_pop;
  logic           w_underrun_evt;
  logic [AW:0]    w_level_nxt;
  stereo_sample_t w_wdata;
  stereo_sample_t w_rdata;

  // wr_ready comes only from registers and enable, never from rd_req.
  assign w_wr_ready     = bus.enable && r_not_full;
  assign w_push         = bus.wr_valid && w_wr_ready;
  assign w_pop          = bus.rd_req && bus.enable && (r_level != LVL_ZERO);
  assign w_underrun_evt = bus.rd_req && bus.enable && (r_level == LVL_ZERO);
  assign w_wdata        = bus.wr_data;

  always_comb begin
    w_level_nxt = r_level;
    if (!bus.enable) begin
      w_level_nxt = LVL_ZERO;
    end else if (w_push && !w_pop) begin
      w_level_nxt = r_level + LVL_ONE;
    end else if (w_pop && !w_push) begin
      w_level_nxt = r_level - LVL_ONE;
    end else begin
      w_level_nxt = r_level;
    end
  end

  // r_not_full stays low through reset so wr_ready opens one cycle after release.
  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) begin
      r_level    <= LVL_ZERO;
      r_not_full <= 1'b0;
    end else begin
      r_level    <= w_level_nxt;
      r_not_full <= (w_level_nxt != LVL_FULL);
    end
  end

  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) begin
      r_wptr <= PTR_ZERO;
      r_rptr <= PTR_ZERO;
    end else if (!bus.enable) begin
      r_wptr <= PTR_ZERO;
      r_rptr <= PTR_ZERO;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
    end
  end

  // Output qualifier: RAM read data is shown only after a real pop.
  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) begin
      r_out_valid <= 1'b0;
    end else if (!bus.enable) begin
      r_out_valid <= 1'b0;
    end else if (w_pop) begin
      r_out_valid <= 1'b1;
    end else if (w_underrun_evt) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) begin
      r_underrun <= 1'b0;
    end else if (w_underrun_evt) begin
      r_underrun <= 1'b1;
    end else if (bus.underrun_clr) begin
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= r_underrun;
    end
  end

  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) begin
      r_irq_low <= 1'b0;
    end else begin
      r_irq_low <= bus.enable && (r_level <= bus.lowwater);
    end
  end

  mcpu_soc_audio_fifo_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk   (clkrst_core_clk),
    .i_we    (w_push),
    .i_waddr (r_wptr),
    .i_wdata (w_wdata),
    .i_re    (w_pop),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  assign bus.wr_ready = w_wr_ready;
  assign bus.rd_left  = (r_out_valid && bus.enable) ? w_rdata.left  : {SAMPLE_W{1'b0}};
  assign bus.rd_right = (r_out_valid && bus.enable) ? w_rdata.right : {SAMPLE_W{1'b0}};
  assign bus.level    = r_level;
  assign bus.irq_low  = r_irq_low && bus.enable;
  assign bus.underrun = r_underrun;

endmodule

// File: tb/tb_mcpu_soc_audio_sample_fifo.sv
// Self-checking bench for the audio sample FIFO against a queue-based reference model.
module tb_mcpu_soc_audio_sample_fifo;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mcpu_soc_audio_sample_fifo_if #(.AW(AW)) bus ();

  mcpu_soc_audio_sample_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clkrst_core_clk (clk),
    .clkrst_core_rst (rst),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] q[$];
  logic [31:0] m_out;
  logic        m_und;
  logic        m_irq;
  logic        m_armed;

  task automatic idle_inputs();
    bus.wr_valid     = 1'b0;
    bus.rd_req       = 1'b0;
    bus.underrun_clr = 1'b0;
  endtask

  // Advance the model by one clock from the current inputs, then the DUT.
  task automatic tick();
    int   sz;
    logic rdy;
    sz    = q.size();
    rdy   = bus.enable && m_armed && (sz != DEPTH);
    m_irq = bus.enable && (sz <= int'(bus.lowwater));
    if (!bus.enable) begin
      q.delete();
      m_out = 32'h0;
      if (bus.underrun_clr) m_und = 1'b0;
    end else begin
      if (bus.rd_req && sz != 0) m_out = q.pop_front();
      else if (bus.rd_req) m_out = 32'h0;
      if (bus.wr_valid && rdy) q.push_back(bus.wr_data);
      if (bus.rd_req && sz == 0) m_und = 1'b1;
      else if (bus.underrun_clr) m_und = 1'b0;
    end
    m_armed = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.enable   = 1'b1;
    bus.lowwater = 7'd0;
    bus.wr_data  = 32'h0;
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.level !== 7'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", bus.level); end
    checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready: got %b want 0", bus.wr_ready); end
    checks++; if ({bus.rd_left, bus.rd_right} !== 32'h0) begin errors++; $display("FAIL reset_outputs: got %h want 0", {bus.rd_left, bus.rd_right}); end
    checks++; if (bus.underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b want 0", bus.underrun); end
    checks++; if (bus.irq_low !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", bus.irq_low); end
    q.delete();
    m_out = 32'h0; m_und = 1'b0; m_irq = 1'b0; m_armed = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL release_wr_ready: got %b want 0", bus.wr_ready); end
    tick();
    checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL first_cycle_wr_ready: got %b want 1", bus.wr_ready); end
  endtask

  task automatic test_basic();
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'h1234_ABCD; tick();
    bus.wr_data  = 32'h0001_FFFF; tick();
    bus.wr_valid = 1'b0;
    checks++; if (bus.level !== 7'd2) begin errors++; $display("FAIL basic_level2: got %0d want 2", bus.level); end
    bus.rd_req = 1'b1; tick(); bus.rd_req = 1'b0;
    checks++; if ({bus.rd_left, bus.rd_right} !== 32'h1234_ABCD) begin errors++; $display("FAIL basic_pop1: got %h want 1234abcd", {bus.rd_left, bus.rd_right}); end
    checks++; if (bus.level !== 7'd1) begin errors++; $display("FAIL basic_level1: got %0d want 1", bus.level); end
    tick();
    checks++; if ({bus.rd_left, bus.rd_right} !== 32'h1234_ABCD) begin errors++; $display("FAIL basic_hold: got %h want 1234abcd", {bus.rd_left, bus.rd_right}); end
    bus.rd_req = 1'b1; tick(); bus.rd_req = 1'b0;
    checks++; if ({bus.rd_left, bus.rd_right} !== 32'h0001_FFFF) begin errors++; $display("FAIL basic_pop2: got %h want 0001ffff", {bus.rd_left, bus.rd_right}); end
    checks++; if (bus.level !== 7'd0) begin errors++; $display("FAIL basic_level0: got %0d want 0", bus.level); end
  endtask

  task automatic test_full();
    logic [31:0] first;
    bus.wr_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.wr_data = $urandom;
      tick();
      if (i == DEPTH - 2) begin
        checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL full_ready_at63: got %b want 1", bus.wr_ready); end
      end
    end
    checks++; if (bus.level !== 7'd64) begin errors++; $display("FAIL full_level: got %0d want 64", bus.level); end
    checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL full_wr_ready: got %b want 0", bus.wr_ready); end
    first       = q[0];
    bus.wr_data = $urandom;
    bus.rd_req  = 1'b1;
    tick();
    idle_inputs();
    checks++; if (bus.level !== 7'd63) begin errors++; $display("FAIL full_push_pop_level: got %0d want 63", bus.level); end
    checks++; if ({bus.rd_left, bus.rd_right} !== first) begin errors++; $display("FAIL full_first_out: got %h want %h", {bus.rd_left, bus.rd_right}, first); end
    while (q.size() > 0) begin
      bus.rd_req = 1'b1;
      tick();
      checks++; if ({bus.rd_left, bus.rd_right} !== m_out) begin errors++; $display("FAIL full_drain: got %h want %h", {bus.rd_left, bus.rd_right}, m_out); end
    end
    bus.rd_req = 1'b0;
    checks++; if (bus.level !== 7'd0) begin errors++; $display("FAIL full_drained_level: got %0d want 0", bus.level); end
  endtask

  task automatic test_underrun();
    bus.rd_req = 1'b1; tick(); bus.rd_req = 1'b0;
    checks++; if ({bus.rd_left, bus.rd_right} !== 32'h0) begin errors++; $display("FAIL und_outputs: got %h want 0", {bus.rd_left, bus.rd_right}); end
    checks++; if (bus.underrun !== 1'b1) begin errors++; $display("FAIL und_set: got %b want 1", bus.underrun); end
    tick();
    checks++; if (bus.underrun !== 1'b1) begin errors++; $display("FAIL und_sticky: got %b want 1", bus.underrun); end
    bus.underrun_clr = 1'b1; tick(); bus.underrun_clr = 1'b0;
    checks++; if (bus.underrun !== 1'b0) begin errors++; $display("FAIL und_clear: got %b want 0", bus.underrun); end
    bus.underrun_clr = 1'b1; bus.rd_req = 1'b1; tick(); idle_inputs();
    checks++; if (bus.underrun !== 1'b1) begin errors++; $display("FAIL und_set_wins: got %b want 1", bus.underrun); end
    bus.rd_req = 1'b1; bus.wr_valid = 1'b1; bus.wr_data = 32'hCAFE_5A5A; tick(); idle_inputs();
    checks++; if (bus.level !== 7'd1) begin errors++; $display("FAIL und_push_stored: got %0d want 1", bus.level); end
    checks++; if ({bus.rd_left, bus.rd_right} !== 32'h0) begin errors++; $display("FAIL und_no_bypass: got %h want 0", {bus.rd_left, bus.rd_right}); end
    bus.rd_req = 1'b1; tick(); bus.rd_req = 1'b0;
    checks++; if ({bus.rd_left, bus.rd_right} !== 32'hCAFE_5A5A) begin errors++; $display("FAIL und_pop_after: got %h want cafe5a5a", {bus.rd_left, bus.rd_right}); end
    bus.underrun_clr = 1'b1; tick(); bus.underrun_clr = 1'b0;
    checks++; if (bus.underrun !== 1'b0) begin errors++; $display("FAIL und_final_clear: got %b want 0", bus.underrun); end
  endtask

  task automatic test_lowwater();
    bus.lowwater = 7'd8;
    bus.wr_valid = 1'b1;
    repeat (10) begin bus.wr_data = $urandom; tick(); end
    bus.wr_valid = 1'b0;
    tick();
    checks++; if (bus.level !== 7'd10 || bus.irq_low !== 1'b0) begin errors++; $display("FAIL lw_at10: got level %0d irq %b want 10/0", bus.level, bus.irq_low); end
    bus.rd_req = 1'b1; tick();
    checks++; if (bus.level !== 7'd9) begin errors++; $display("FAIL lw_level9: got %0d want 9", bus.level); end
    tick(); bus.rd_req = 1'b0;
    checks++; if (bus.level !== 7'd8 || bus.irq_low !== 1'b0) begin errors++; $display("FAIL lw_reach8: got level %0d irq %b want 8/0", bus.level, bus.irq_low); end
    tick();
    checks++; if (bus.irq_low !== 1'b1) begin errors++; $display("FAIL lw_assert: got %b want 1", bus.irq_low); end
    bus.wr_valid = 1'b1; bus.wr_data = $urandom; tick(); bus.wr_valid = 1'b0;
    checks++; if (bus.level !== 7'd9 || bus.irq_low !== 1'b1) begin errors++; $display("FAIL lw_refill9: got level %0d irq %b want 9/1", bus.level, bus.irq_low); end
    tick();
    checks++; if (bus.irq_low !== 1'b0) begin errors++; $display("FAIL lw_deassert: got %b want 0", bus.irq_low); end
    while (q.size() > 0) begin bus.rd_req = 1'b1; tick(); end
    bus.rd_req = 1'b0;
  endtask

  task automatic test_enable_flush();
    logic [31:0] first;
    bus.lowwater = 7'd15;
    bus.wr_valid = 1'b1;
    repeat (10) begin bus.wr_data = $urandom; tick(); end
    checks++; if (bus.level !== 7'd10 || bus.irq_low !== 1'b1) begin errors++; $display("FAIL en_pre: got level %0d irq %b want 10/1", bus.level, bus.irq_low); end
    bus.enable = 1'b0; bus.rd_req = 1'b1; bus.wr_data = $urandom;
    #1;
    checks++; if (bus.wr_ready !== 1'b0 || bus.irq_low !== 1'b0) begin errors++; $display("FAIL en_low_gating: got ready %b irq %b want 0/0", bus.wr_ready, bus.irq_low); end
    tick();
    checks++; if (bus.level !== 7'd0 || {bus.rd_left, bus.rd_right} !== 32'h0) begin errors++; $display("FAIL en_flush: got level %0d out %h want 0/0", bus.level, {bus.rd_left, bus.rd_right}); end
    checks++; if (bus.underrun !== 1'b0) begin errors++; $display("FAIL en_rd_ignored: got %b want 0", bus.underrun); end
    bus.enable = 1'b1; bus.rd_req = 1'b0;
    first = $urandom; bus.wr_data = first; tick();
    repeat (9) begin bus.wr_data = $urandom; tick(); end
    bus.wr_valid = 1'b0;
    checks++; if (bus.level !== 7'd10) begin errors++; $display("FAIL en_refill_level: got %0d want 10", bus.level); end
    bus.rd_req = 1'b1; tick(); bus.rd_req = 1'b0;
    checks++; if ({bus.rd_left, bus.rd_right} !== first) begin errors++; $display("FAIL en_first_popped: got %h want %h", {bus.rd_left, bus.rd_right}, first); end
    while (q.size() > 0) begin bus.rd_req = 1'b1; tick(); end
    bus.rd_req   = 1'b0;
    bus.lowwater = 7'd0;
  endtask

  task automatic test_random_stream();
    int pushed = 0;
    int cycles = 0;
    int wr_pct;
    int rd_pct;
    logic wv;
    bus.lowwater = 7'($urandom_range(0, DEPTH));
    while ((pushed < 200 || q.size() > 0) && cycles < 5000) begin
      wr_pct = (cycles / 64) % 2 == 0 ? 75 : 35;
      rd_pct = (cycles / 64) % 2 == 0 ? 30 : 70;
      wv = (pushed < 200) && ($urandom_range(0, 99) < wr_pct);
      bus.wr_valid = wv;
      bus.wr_data  = $urandom;
      bus.rd_req   = (q.size() > 0) && ($urandom_range(0, 99) < rd_pct);
      if (wv && m_armed && q.size() != DEPTH) pushed++;
      tick();
      cycles++;
      checks++; if ({bus.rd_left, bus.rd_right} !== m_out) begin errors++; $display("FAIL rnd_data: cyc %0d got %h want %h", cycles, {bus.rd_left, bus.rd_right}, m_out); end
      checks++; if (int'(bus.level) != q.size()) begin errors++; $display("FAIL rnd_level: cyc %0d got %0d want %0d", cycles, bus.level, q.size()); end
      checks++; if (bus.wr_ready !== (q.size() != DEPTH)) begin errors++; $display("FAIL rnd_ready: cyc %0d got %b", cycles, bus.wr_ready); end
      checks++; if (bus.irq_low !== m_irq) begin errors++; $display("FAIL rnd_irq: cyc %0d got %b want %b", cycles, bus.irq_low, m_irq); end
      checks++; if (bus.underrun !== m_und) begin errors++; $display("FAIL rnd_underrun: cyc %0d got %b want %b", cycles, bus.underrun, m_und); end
    end
    idle_inputs();
    checks++; if (cycles >= 5000) begin errors++; $display("FAIL rnd_timeout: got %0d cycles want < 5000", cycles); end
    checks++; if (bus.level !== 7'd0) begin errors++; $display("FAIL rnd_final_level: got %0d want 0", bus.level); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_underrun();
    test_lowwater();
    test_enable_flush();
    test_random_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
